dmem_responder: RTL and testbench

- Data-memory responder on the processor's memory-request interface. It services the mem_read, mem_write and second_cycle requests driven by the multi-cycle control unit.
- Holds the word-addressed data array and inserts programmable wait states. Sequences the two halves of LDW/SDW double-word accesses.
- Flags illegal accesses (out of range, misaligned double-word, orphan second cycle, read+write conflict) back to the control path.

---
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory responder for LW/SW/LDW/SDW requests, with illegal-access flagging.
// Latency: request sampled in IDLE at T, mem_ready pulse at T+1+WAIT_STATES.
// Backpressure: busy from capture through the response cycle; inputs ignored until back in IDLE.
// Optional: define DMEM_ACCESS_CNT_EN to add saturating rd_count/wr_count outputs.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              dword,
    input  logic              second_cycle,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mem_ready,
    output logic              busy,
`ifdef DMEM_ACCESS_CNT_EN
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
`endif
    output logic              addr_error
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      WS        = 4'(WAIT_STATES);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state, state_nxt;
    logic [3:0]         wcnt;
    logic [31:0]        mem [DEPTH];

    // Request captured in IDLE; held while busy.
    logic               req_rd, req_wr, req_dw, req_sc, req_err;
    logic [ADDR_W-1:0]  req_eff;
    logic [31:0]        req_wdata;

    // Double-word sequencing: base of the pair and whether phase 2 may follow.
    logic               pending;
    logic [ADDR_W-1:0]  base;

    logic [ADDR_W-1:0]  cap_eff;
    logic               cap_err;
    logic               start;
    logic               commit;

    // Descriptor of the access being committed: live inputs when going
    // straight from IDLE to RESP, otherwise the captured copy.
    logic               act_rd, act_wr, act_dw, act_sc, act_err;
    logic [ADDR_W-1:0]  act_eff;
    logic [31:0]        act_wdata;
    logic [IDX_W-1:0]   act_idx;

    // Effective address and error classification of the incoming request.
    always_comb begin
        cap_eff = second_cycle ? (base + ADDR_W'(1)) : addr;
        cap_err = (mem_read & mem_write)
                | ({1'b0, cap_eff} >= DEPTH_EXT)
                | (dword & ~second_cycle & addr[0])
                | (second_cycle & ~pending);
    end

    assign start  = (state == S_IDLE) & (mem_read | mem_write);
    assign commit = (state_nxt == S_RESP);

    // Select which request descriptor the commit edge acts on.
    always_comb begin
        if (state == S_IDLE) begin
            act_rd    = mem_read;
            act_wr    = mem_write;
            act_dw    = dword;
            act_sc    = second_cycle;
            act_err   = cap_err;
            act_eff   = cap_eff;
            act_wdata = wdata;
        end else begin
            act_rd    = req_rd;
            act_wr    = req_wr;
            act_dw    = req_dw;
            act_sc    = req_sc;
            act_err   = req_err;
            act_eff   = req_eff;
            act_wdata = req_wdata;
        end
        act_idx = act_eff[IDX_W-1:0];
    end

    // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (WS != 4'd0) ? S_WAIT : S_RESP;
            S_WAIT:  if (wcnt == 4'd0) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, wait counter, request capture, pair tracking and read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            wcnt      <= 4'd0;
            req_rd    <= 1'b0;
            req_wr    <= 1'b0;
            req_dw    <= 1'b0;
            req_sc    <= 1'b0;
            req_err   <= 1'b0;
            req_eff   <= '0;
            req_wdata <= 32'd0;
            pending   <= 1'b0;
            base      <= '0;
            rdata     <= 32'd0;
        end else begin
            state <= state_nxt;
            if (start) begin
                wcnt      <= WS - 4'd1;
                req_rd    <= mem_read;
                req_wr    <= mem_write;
                req_dw    <= dword;
                req_sc    <= second_cycle;
                req_err   <= cap_err;
                req_eff   <= cap_eff;
                req_wdata <= wdata;
            end else if (state == S_WAIT) begin
                wcnt <= wcnt - 4'd1;
            end
            if (commit) begin
                if (act_sc) begin
                    pending <= 1'b0;
                end else if (act_dw & ~act_err) begin
                    pending <= 1'b1;
                    base    <= act_eff;
                end else begin
                    pending <= 1'b0;
                end
                if (act_rd & ~act_err) rdata <= mem[act_idx];
            end
        end
    end

    // Array write, only for a legal store reaching the response.
    always_ff @(posedge clk) begin
        if (commit & act_wr & ~act_err) mem[act_idx] <= act_wdata;
    end

`ifdef DMEM_ACCESS_CNT_EN
    // Saturating counters of legal completed reads and writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (commit & ~act_err) begin
            if (act_rd && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            if (act_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end
    end
`endif

    assign mem_ready  = (state == S_RESP);
    assign busy       = (state != S_IDLE);
    assign addr_error = mem_ready & req_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench driving two responders (WAIT_STATES=0 and 3) with a response scoreboard.
// Latency: each access waits for mem_ready within a bounded cycle budget.
// Backpressure: requests are dropped right after capture; the DUT ignores inputs while busy.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd [2];
    logic        wr [2];
    logic        dword;
    logic        second;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata [2];
    logic        rdy [2];
    logic        bsy [2];
    logic        aerr [2];
`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rdc [2];
    logic [15:0] wrc [2];
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .ADDR_W(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]),
        .dword(dword), .second_cycle(second), .addr(addr), .wdata(wdata),
        .rdata(rdata[0]), .mem_ready(rdy[0]), .busy(bsy[0]),
`ifdef DMEM_ACCESS_CNT_EN
        .rd_count(rdc[0]), .wr_count(wrc[0]),
`endif
        .addr_error(aerr[0])
    );

    dmem_responder #(.DEPTH(256), .ADDR_W(32), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]),
        .dword(dword), .second_cycle(second), .addr(addr), .wdata(wdata),
        .rdata(rdata[1]), .mem_ready(rdy[1]), .busy(bsy[1]),
`ifdef DMEM_ACCESS_CNT_EN
        .rd_count(rdc[1]), .wr_count(wrc[1]),
`endif
        .addr_error(aerr[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one access on instance d, push its expected response, then
    // pop and compare once the DUT answers.
    task automatic access(input int d, input string tag, input logic r_i, input logic w_i,
                          input logic dw_i, input logic sc_i, input logic [31:0] a_i,
                          input logic [31:0] wd_i, input logic e_exp,
                          input logic [31:0] rd_exp, input int lat_exp);
        exp_t x;
        int   n;
        x.err   = e_exp;
        x.rdata = rd_exp;
        x.lat   = lat_exp;
        sbq.push_back(x);
        @(negedge clk);
        rd[d]  = r_i;
        wr[d]  = w_i;
        dword  = dw_i;
        second = sc_i;
        addr   = a_i;
        wdata  = wd_i;
        @(posedge clk);
        #1;
        rd[d]  = 1'b0;
        wr[d]  = 1'b0;
        dword  = 1'b0;
        second = 1'b0;
        check({tag, ".busy"}, 32'(bsy[d]), 32'd1);
        n = 1;
        while (!rdy[d] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        x = sbq.pop_front();
        check({tag, ".ready"}, 32'(rdy[d]), 32'd1);
        check({tag, ".lat"}, 32'(n), 32'(x.lat));
        check({tag, ".err"}, 32'(aerr[d]), 32'(x.err));
        check({tag, ".rdata"}, rdata[d], x.rdata);
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, 32'(rdy[d]), 32'd0);
        check({tag, ".idle"}, 32'(bsy[d]), 32'd0);
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        reset  = 1'b0;
        rd[0]  = 1'b0; rd[1] = 1'b0;
        wr[0]  = 1'b0; wr[1] = 1'b0;
        dword  = 1'b0;
        second = 1'b0;
        addr   = 32'd0;
        wdata  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst.rdata", rdata[d], 32'd0);
            check("rst.ready", 32'(rdy[d]), 32'd0);
            check("rst.busy", 32'(bsy[d]), 32'd0);
            check("rst.err", 32'(aerr[d]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        // WAIT_STATES=0 instance
        access(0, "sw5",      0, 1, 0, 0, 32'd5,  32'hDEAD_BEEF, 0, 32'd0,         1);
        access(0, "lw5",      1, 0, 0, 0, 32'd5,  32'd0,         0, 32'hDEAD_BEEF, 1);
        access(0, "sdw.p1",   0, 1, 1, 0, 32'd10, 32'd1,         0, 32'hDEAD_BEEF, 1);
        access(0, "sdw.p2",   0, 1, 1, 1, 32'd99, 32'd2,         0, 32'hDEAD_BEEF, 1);
        access(0, "ldw.p1",   1, 0, 1, 0, 32'd10, 32'd0,         0, 32'd1,         1);
        access(0, "ldw.p2",   1, 0, 1, 1, 32'd99, 32'd0,         0, 32'd2,         1);
        access(0, "ldw7.p1",  1, 0, 1, 0, 32'd7,  32'd0,         1, 32'd2,         1);
        access(0, "ldw7.p2",  1, 0, 1, 1, 32'd7,  32'd0,         1, 32'd2,         1);
        access(0, "lw.depth", 1, 0, 0, 0, 32'd256, 32'd0,        1, 32'd2,         1);
        access(0, "lw.high",  1, 0, 0, 0, 32'h8000_0005, 32'd0,  1, 32'd2,         1);
        access(0, "rdwr",     1, 1, 0, 0, 32'd5,  32'd0,         1, 32'd2,         1);
        access(0, "lw5.keep", 1, 0, 0, 0, 32'd5,  32'd0,         0, 32'hDEAD_BEEF, 1);
        access(0, "sdw20.p1", 0, 1, 1, 0, 32'd20, 32'h55,        0, 32'hDEAD_BEEF, 1);
        access(0, "sw30",     0, 1, 0, 0, 32'd30, 32'h66,        0, 32'hDEAD_BEEF, 1);
        access(0, "orphan",   0, 1, 1, 1, 32'd20, 32'h77,        1, 32'hDEAD_BEEF, 1);
        access(0, "lw20",     1, 0, 0, 0, 32'd20, 32'd0,         0, 32'h55,        1);
        access(0, "lw30",     1, 0, 0, 0, 32'd30, 32'd0,         0, 32'h66,        1);
        access(0, "sdw40.p1", 0, 1, 1, 0, 32'd40, 32'h40,        0, 32'h66,        1);

        // WAIT_STATES=3 instance
        access(1, "ws3.sw2",  0, 1, 0, 0, 32'd2,  32'h1234,      0, 32'd0,         4);
        access(1, "ws3.lw2",  1, 0, 0, 0, 32'd2,  32'd0,         0, 32'h1234,      4);
        access(1, "ws3.sw4",  0, 1, 0, 0, 32'd4,  32'hAAAA,      0, 32'h1234,      4);

        // Reset pulled while the WAIT_STATES=3 store sits in WAIT
        @(negedge clk);
        wr[1] = 1'b1;
        addr  = 32'd4;
        wdata = 32'd7;
        @(posedge clk);
        #1;
        wr[1] = 1'b0;
        check("rstmid.busy", 32'(bsy[1]), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rstmid.ready", 32'(rdy[1]), 32'd0);
        check("rstmid.busy0", 32'(bsy[1]), 32'd0);
        check("rstmid.err", 32'(aerr[1]), 32'd0);
        check("rstmid.rdata", rdata[1], 32'd0);
        check("rstmid.rdata0", rdata[0], 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen  = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rdy[1]) seen = 1'b1;
        end
        check("rstmid.noresp", 32'(seen), 32'd0);
        access(1, "ws3.lw4",  1, 0, 0, 0, 32'd4,  32'd0,         0, 32'hAAAA,      4);
        // Reset cleared the pair started before it
        access(0, "rst.p2",   0, 1, 1, 1, 32'd40, 32'h41,        1, 32'd0,         1);

`ifdef DMEM_ACCESS_CNT_EN
        access(0, "cnt.lw5",  1, 0, 0, 0, 32'd5,  32'd0,         0, 32'hDEAD_BEEF, 1);
        access(0, "cnt.lw10", 1, 0, 0, 0, 32'd10, 32'd0,         0, 32'd1,         1);
        access(0, "cnt.sw12", 0, 1, 0, 0, 32'd12, 32'hC,         0, 32'd1,         1);
        access(0, "cnt.lw11", 1, 0, 0, 0, 32'd11, 32'd0,         0, 32'd2,         1);
        access(0, "cnt.sw13", 0, 1, 0, 0, 32'd13, 32'hD,         0, 32'd2,         1);
        access(0, "cnt.err",  1, 0, 0, 0, 32'd300, 32'd0,        1, 32'd2,         1);
        check("cnt.rd", 32'(rdc[0]), 32'd3);
        check("cnt.wr", 32'(wrc[0]), 32'd2);
        @(negedge clk);
        force dut0.rd_count = 16'hFFFF;
        @(negedge clk);
        release dut0.rd_count;
        access(0, "cnt.sat",  1, 0, 0, 0, 32'd5,  32'd0,         0, 32'hDEAD_BEEF, 1);
        check("cnt.rdsat", 32'(rdc[0]), 32'h0000_FFFF);
`endif

        check("sb.empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
